// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions: reset PC, NOP encoding and the fetch entry
// carried from instruction fetch to decode.
package cpu_pkg;

  localparam logic [31:0] RESET_PC  = 32'h0000_3000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/ifq_storage.sv
// Fetch-queue entry array: DEPTH x 64-bit registers, one synchronous write
// port and one combinational read port.
module ifq_storage #(
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [63:0]   wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [63:0]   rdata_o
);

  logic [63:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/if_id_queue.sv
// IF/ID instruction queue: buffers {pc, instr} pairs between fetch and decode.
// Define IFQ_DELAY_SLOT_EN to keep one entry (the branch delay slot) on flush.
module if_id_queue
  import cpu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             if_valid,
  input  logic [31:0]      if_pc,
  input  logic [31:0]      if_instr,
  output logic             pc_en,
  input  logic             flush,
  input  logic             id_ready,
  output logic             id_valid,
  output logic [31:0]      id_pc,
  output logic [31:0]      id_instr,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic         full, empty, push, pop, wr_en;
  logic [63:0]  rd_data;
  fetch_entry_t head;

  // Handshakes: fetch transfers when if_valid & pc_en & ~flush; decode
  // transfers when id_valid & id_ready. Neither valid depends on its ready.
  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);
  assign push  = if_valid & ~full & ~flush;
  assign pop   = id_valid & id_ready;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    wr_en    = 1'b0;
    if (flush) begin
      // Decode already took the head this cycle, so the pop still retires it.
      rd_ptr_d = rd_ptr_q + PTR_W'(pop);
`ifdef IFQ_DELAY_SLOT_EN
      if ((count_q - CNT_W'(pop)) != '0) begin
        // Oldest survivor stays at the head as the delay slot.
        wr_ptr_d = rd_ptr_d + PTR_W'(1);
        count_d  = CNT_W'(1);
      end else if (if_valid) begin
        // Nothing survives, so wr_ptr_q == rd_ptr_d: the incoming pair is the slot.
        wr_en    = 1'b1;
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
        count_d  = CNT_W'(1);
      end else begin
        wr_ptr_d = rd_ptr_d;
        count_d  = '0;
      end
`else
      wr_ptr_d = rd_ptr_d;
      count_d  = '0;
`endif
    end else begin
      wr_en    = push;
      wr_ptr_d = wr_ptr_q + PTR_W'(push);
      rd_ptr_d = rd_ptr_q + PTR_W'(pop);
      count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  ifq_storage #(
    .DEPTH (DEPTH),
    .AW    (PTR_W)
  ) u_storage (
    .clk     (clk),
    .we_i    (wr_en),
    .waddr_i (wr_ptr_q),
    .wdata_i ({if_pc, if_instr}),
    .raddr_i (rd_ptr_q),
    .rdata_o (rd_data)
  );

  assign head     = fetch_entry_t'(rd_data);
  assign pc_en    = ~full;
  assign id_valid = ~empty;
  assign id_pc    = empty ? RESET_PC  : head.pc;
  assign id_instr = empty ? NOP_INSTR : head.instr;
  assign count    = count_q;

endmodule

// File: tb/tb_if_id_queue.sv
// Bench for if_id_queue: queue-based reference model checked every cycle plus
// directed scenarios with literal expectations; honours IFQ_DELAY_SLOT_EN.
module tb_if_id_queue;
  import cpu_pkg::*;

  localparam int DEPTH = 4;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             if_valid = 1'b0;
  logic [31:0]      if_pc = '0;
  logic [31:0]      if_instr = '0;
  logic             flush = 1'b0;
  logic             id_ready = 1'b0;
  logic             pc_en;
  logic             id_valid;
  logic [31:0]      id_pc;
  logic [31:0]      id_instr;
  logic [CNT_W-1:0] count;

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q[$];
  bit model_ok = 1'b0;

  if_id_queue #(.DEPTH(DEPTH)) dut (
    .clk      (clk),
    .reset    (reset),
    .if_valid (if_valid),
    .if_pc    (if_pc),
    .if_instr (if_instr),
    .pc_en    (pc_en),
    .flush    (flush),
    .id_ready (id_ready),
    .id_valid (id_valid),
    .id_pc    (id_pc),
    .id_instr (id_instr),
    .count    (count)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  function automatic logic [31:0] instr_of(input logic [31:0] pc);
    return pc ^ 32'h2400_0000;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  always @(posedge clk) begin
    int n;
    bit do_pop, do_push;
    logic [63:0] in_e;
    in_e = {if_pc, if_instr};
    if (reset) begin
      exp_q.delete();
      model_ok = 1'b1;
    end else if (model_ok) begin
      n       = exp_q.size();
      do_pop  = (n > 0) && id_ready;
      do_push = if_valid && (n < DEPTH) && !flush;
      if (do_pop) void'(exp_q.pop_front());
      if (flush) begin
`ifdef IFQ_DELAY_SLOT_EN
        if (exp_q.size() > 0) begin : keep_oldest
          logic [63:0] e;
          e = exp_q[0];
          exp_q.delete();
          exp_q.push_back(e);
        end else if (if_valid) begin
          exp_q.push_back(in_e);
        end
`else
        exp_q.delete();
`endif
      end else if (do_push) begin
        exp_q.push_back(in_e);
      end
    end
  end

  // ---------------- scoreboard compare ----------------
  always @(negedge clk) begin
    logic [63:0] head;
    int n;
    if (model_ok) begin
      n    = exp_q.size();
      head = (n > 0) ? exp_q[0] : {RESET_PC, NOP_INSTR};
      check("sb_count", 64'(count), 64'(n));
      check("sb_id_valid", 64'(id_valid), 64'(n > 0));
      check("sb_pc_en", 64'(pc_en), 64'(n < DEPTH));
      check("sb_id_pc", 64'(id_pc), 64'(head[63:32]));
      check("sb_id_instr", 64'(id_instr), 64'(head[31:0]));
      checks++;
      assert (count <= CNT_W'(DEPTH)) else begin
        errors++;
        $display("FAIL count_bound: got %0d limit %0d", count, DEPTH);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input bit v, input logic [31:0] pc, input bit rdy, input bit fl);
    if_valid = v;
    if_pc    = pc;
    if_instr = instr_of(pc);
    id_ready = rdy;
    flush    = fl;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    if_valid = 1'b0;
    id_ready = 1'b0;
    flush    = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("rst_count", 64'(count), 64'd0);
    check("rst_id_valid", 64'(id_valid), 64'd0);
    check("rst_pc_en", 64'(pc_en), 64'd1);
    check("rst_id_pc", 64'(id_pc), 64'h3000);
    check("rst_id_instr", 64'(id_instr), 64'h0);

    // Fill to full with decode stalled.
    for (int i = 0; i < 4; i++) step(1'b1, 32'h3000 + 32'(4 * i), 1'b0, 1'b0);
    check("fill_count", 64'(count), 64'd4);
    check("fill_pc_en", 64'(pc_en), 64'd0);
    check("fill_id_pc", 64'(id_pc), 64'h3000);
    check("fill_id_instr", 64'(id_instr), 64'h2400_3000);
    step(1'b1, 32'h3010, 1'b0, 1'b0);
    check("full_reject_count", 64'(count), 64'd4);

    // Pop while full: no push this cycle, then 0x3010 enters.
    step(1'b1, 32'h3010, 1'b1, 1'b0);
    check("full_pop_count", 64'(count), 64'd3);
    check("full_pop_id_pc", 64'(id_pc), 64'h3004);
    check("full_pop_pc_en", 64'(pc_en), 64'd1);
    step(1'b1, 32'h3010, 1'b0, 1'b0);
    check("refill_count", 64'(count), 64'd4);

    // Steady stream: occupancy 1, head advancing by 4, pointers wrapping.
    do_reset();
    step(1'b1, 32'h3100, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 32'h3104 + 32'(4 * i), 1'b1, 1'b0);
      check("stream_count", 64'(count), 64'd1);
      check("stream_id_pc", 64'(id_pc), 64'(32'h3104 + 32'(4 * i)));
    end

    // Flush with a same-cycle pop; queue holds 0x3004/0x3008/0x300C.
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b1, 32'h3000 + 32'(4 * i), 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b1, 1'b0);
    check("pre_flush_count", 64'(count), 64'd3);
    step(1'b1, 32'h3010, 1'b1, 1'b1);
`ifdef IFQ_DELAY_SLOT_EN
    check("flush_pop_count", 64'(count), 64'd1);
    check("flush_pop_id_pc", 64'(id_pc), 64'h3008);
`else
    check("flush_pop_count", 64'(count), 64'd0);
    check("flush_pop_id_valid", 64'(id_valid), 64'd0);
    check("flush_pop_id_pc", 64'(id_pc), 64'h3000);
`endif
    step(1'b0, 32'h0, 1'b1, 1'b0);
    check("drain_count", 64'(count), 64'd0);

    // Flush on an empty queue with a valid fetch.
    step(1'b1, 32'h3020, 1'b0, 1'b1);
`ifdef IFQ_DELAY_SLOT_EN
    check("flush_empty_count", 64'(count), 64'd1);
    check("flush_empty_id_pc", 64'(id_pc), 64'h3020);
`else
    check("flush_empty_count", 64'(count), 64'd0);
    check("flush_empty_id_pc", 64'(id_pc), 64'h3000);
`endif
    step(1'b1, 32'h3024, 1'b0, 1'b0);
`ifdef IFQ_DELAY_SLOT_EN
    check("post_flush_count", 64'(count), 64'd2);
    check("post_flush_id_pc", 64'(id_pc), 64'h3020);
`else
    check("post_flush_count", 64'(count), 64'd1);
    check("post_flush_id_pc", 64'(id_pc), 64'h3024);
`endif

    // Reset mid-stream overrides pop and push.
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b1, 32'h3000 + 32'(4 * i), 1'b0, 1'b0);
    check("pre_reset_count", 64'(count), 64'd3);
    reset = 1'b1;
    step(1'b1, 32'h300C, 1'b1, 1'b0);
    reset = 1'b0;
    check("midrst_count", 64'(count), 64'd0);
    check("midrst_id_valid", 64'(id_valid), 64'd0);
    check("midrst_id_instr", 64'(id_instr), 64'd0);
    check("midrst_pc_en", 64'(pc_en), 64'd1);

    // Mixed pattern with periodic flushes, checked by the model.
    for (int i = 0; i < 48; i++) begin
      step((i % 4) != 3, 32'h4000 + 32'(4 * i), (i % 3) == 0, (i % 11) == 7);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/if_id_queue.md
Name: if_id_queue

Overview:
- Instruction fetch queue that sits directly downstream of the PC register and instruction memory, and upstream of decode.
- Buffers {pc, instr} pairs fetched each cycle and presents the oldest pair to decode with a valid/ready handshake.
- Drives the PC's enable so fetch stalls when the queue is full.
- Discards queued wrong-path instructions on a redirect (flush).

Parameters:
- DEPTH, 4: number of entries; must be a power of two and at least 2.
- CNT_W, $clog2(DEPTH+1): width of the occupancy count.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- reset  in  1  synchronous, active-high; clears the queue on posedge clk while high.
- if_valid  in  1  fetch presents a valid pair this cycle.
- if_pc  in  32  address of the fetched instruction (PC output).
- if_instr  in  32  instruction word read from instruction memory.
- pc_en  out  1  enable to the PC register; high means fetch may advance.
- flush  in  1  redirect from branch/jump resolution; discards queued entries.
- id_ready  in  1  decode accepts the head entry this cycle.
- id_valid  out  1  head entry valid.
- id_pc  out  32  head entry PC.
- id_instr  out  32  head entry instruction.
- count  out  CNT_W  current occupancy.

Behaviour:
- Storage: circular buffer; rd_ptr and wr_ptr of width log2(DEPTH), plus count; pointers wrap modulo DEPTH.
- Reset values:
  - count = 0; rd_ptr = wr_ptr = 0.
  - id_valid = 0, pc_en = 1.
  - id_pc = 32'h00003000, id_instr = 32'h00000000 (NOP).
- Derived signals:
  - full = (count == DEPTH); empty = (count == 0).
  - push = if_valid & ~full & ~flush; pop = id_valid & id_ready.
- Output timing:
  - pc_en = ~full, combinational. A push while full is therefore never accepted, even if a pop happens the same cycle; no full-with-pop bypass.
  - id_valid = ~empty.
  - id_pc/id_instr are read combinationally from the head entry. When empty they show RESET_PC/NOP.
- Latency: an entry pushed at edge N is visible on id_* after edge N. Minimum fetch-to-decode latency is 1 cycle; there is no empty bypass.
- Simultaneous push and pop: count is unchanged and both pointers advance. This is legal at any count except full, where push is blocked.
- Pop when empty is impossible because id_valid is 0.
- Flush (macro off):
  - At the next edge, count = 0 and rd_ptr = wr_ptr.
  - A same-cycle pop still completes; decode took it.
  - The same-cycle push is discarded.
- Priority: reset > flush > push/pop.
- Reset asserted mid-stream empties the queue regardless of id_ready, flush or if_valid.
- count never exceeds DEPTH and never underflows. The bench checks this with an assertion.

Optional Feature:
- Macro: IFQ_DELAY_SLOT_EN (MIPS branch delay slot preservation).
- Defined: flush keeps exactly one entry, the oldest entry surviving after this cycle's pop.
  - If a surviving entry exists, it is kept at the head, count becomes 1, and the same-cycle push is discarded.
  - If no entry survives and if_valid is high, the incoming pair is kept as the delay slot (count = 1).
  - Otherwise the queue empties.
- Undefined: flush discards everything, as described in Behaviour.

Decomposition:
- Shared package cpu_pkg holds:
  - RESET_PC = 32'h00003000;
  - NOP_INSTR = 32'h00000000;
  - typedef fetch_entry_t {pc[31:0], instr[31:0]}.
- One natural sub-module: ifq_storage, a DEPTH x 64-bit register array with one write port and one combinational read port.
- Pointer, count and flush control stay in if_id_queue.

Test Plan:
- Reset, then if_valid=1 with pc 0x3000/0x3004/0x3008/0x300C and id_ready=0 → count reaches 4 and pc_en=0 after the 4th edge; a 5th pair (0x3010) is not accepted.
- Full queue, id_ready=1 for one cycle with if_valid=1 → head 0x3000 popped, no push that cycle, count=3; next cycle pc_en=1 and 0x3010 accepted.
- Steady stream with id_ready=1 and if_valid=1 for 20 cycles → count stays 1, id_pc increments by 4 each cycle, pointers wrap past DEPTH without gaps or duplicates.
- Queue holding 0x3004/0x3008/0x300C, flush=1 with pop=1 → macro off: count=0, id_valid=0, id_pc=0x3000. Macro on: count=1, id_pc=0x3008.
- Empty queue, flush=1 with if_valid=1 and pc 0x3020 → macro off: count=0. Macro on: count=1, id_pc=0x3020.
- reset=1 asserted with count=3 and id_ready=1 → next edge count=0, id_valid=0, id_instr=0, pc_en=1.
